serial_mult_seq: RTL
====================

Name: serial_mult_seq

Overview:
Sequencer for the bit-serial 4-bit-Y multiplier stage. Accepts a parallel operand pair over a valid/ready handshake and drives the multiplier's serial X input (LSB first, zero-padded), parallel Y input and active-low clear control. Deserializes the returned serial product stream into a parallel result word, which it presents downstream with a valid/ready handshake. Sits between the operand source and the multiplier, wrapping both its input side and its output side.

Parameters:
XW, 4, width of serial operand A, in bits
YW, 4, width of parallel operand B; fixed at 4 to match the multiplier
PW, XW+YW, product width and number of product bits collected
MUL_LAT, 1, cycles from driving x bit k to prod_ser carrying product bit k

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-low
start_valid  in  1  operand pair offered
start_ready  out  1  block can accept operands
a_in  in  XW  operand A, unsigned; serialized onto x_ser
b_in  in  YW  operand B, unsigned; driven onto y_par
x_ser  out  1  serial A bit to multiplier x
y_par  out  YW  parallel B to multiplier y
mctrl  out  1  multiplier ctrl; low clears all multiplier flops on the next edge
prod_ser  in  1  serial product bit from multiplier
result  out  PW  collected product, unsigned
res_valid  out  1  result available
res_ready  in  1  downstream accepts result

Behaviour:
- States: IDLE, SHIFT, DONE. Counter cnt is 0..PW wide enough to hold PW.
- Reset (rst low at an edge): state=IDLE, cnt=0, result=0, res_valid=0, latched A/B=0.
- While rst is low, mctrl=0 and x_ser=0 combinationally, so the multiplier clears on the same edge.
- IDLE:
  - start_ready=1, mctrl=0, x_ser=0.
  - On start_valid&start_ready: latch a_in->areg and b_in->breg, cnt<=0, go to SHIFT.
  - Because mctrl is 0 on that edge, the multiplier is flushed.
- SHIFT:
  - start_ready=0, mctrl=1, y_par=breg (stable for the whole state).
  - x_ser = areg[cnt] when cnt<XW, else 0.
  - At each edge with cnt>=MUL_LAT: result <= {prod_ser, result[PW-1:1]}. prod_ser in the cycle with cnt=c is product bit c-MUL_LAT.
  - cnt increments each edge. At the edge where cnt==PW+MUL_LAT-1, perform the last capture and go to DONE.
  - SHIFT therefore lasts exactly PW+MUL_LAT cycles and performs exactly PW captures.
- DONE:
  - res_valid=1, result held, mctrl=0, x_ser=0, start_ready=0.
  - On res_valid&res_ready: go to IDLE and clear res_valid. result holds its value until the next capture.
  - start_valid is ignored in DONE; no overlap between transactions.
- y_par equals breg in all states (0 after reset).
- Latency: res_valid rises PW+MUL_LAT edges after the accepting edge. Defaults: 9 edges.
- Throughput: one transaction per PW+MUL_LAT+2 cycles minimum (IDLE accept, SHIFT, DONE hand-off).
- Arithmetic: result = areg*breg, unsigned, exact in PW bits; no overflow is possible.
- Backpressure: res_ready low holds DONE indefinitely; result and res_valid stay stable.
- Reset mid-SHIFT or mid-DONE: abort the transaction and apply reset values. No partial result is presented.
- x_ser, mctrl and start_ready are decoded from state/cnt and are glitch-free relative to clk edges.

Test Plan:
- Reset, then a_in=13, b_in=11 accepted -> x_ser sequence 1,0,1,1,0,0,0,0 in SHIFT. res_valid 9 edges after accept, result=0x8F (143).
- a_in=15, b_in=15 -> result=0xE1 (225). All-ones operands exercise carry propagation through every adder stage.
- a_in=0, b_in=9, then a_in=7, b_in=0 -> result=0x00 both times. mctrl is low for at least one edge between the transactions.
- Back-to-back: res_ready tied high, start_valid held high with operand pairs (3,5), (12,10), (1,1) -> results 0x0F, 0x78, 0x01, one transaction every 11 cycles; start_ready high only in IDLE.
- Backpressure: res_ready low for 20 cycles after res_valid with a=9, b=6 -> result stays 0x36, res_valid stays 1, start_ready stays 0. Release -> IDLE next edge.
- rst low for one edge at cnt=4 of SHIFT with a=11, b=13 -> IDLE, result=0, res_valid=0, mctrl=0 during the reset cycle. Then a fresh a=11, b=13 -> result=0x8F.

Source files
------------

// File: rtl/serial_mult_seq.sv
// Sequencer for the bit-serial multiplier stage: it serializes operand A LSB-first,
// holds B in parallel, and deserializes the returned product stream into a result word.
module serial_mult_seq #(
    parameter int XW      = 4,
    parameter int YW      = 4,
    parameter int PW      = XW + YW,
    parameter int MUL_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_valid,
    output logic          start_ready,
    input  logic [XW-1:0] a_in,
    input  logic [YW-1:0] b_in,
    output logic          x_ser,
    output logic [YW-1:0] y_par,
    output logic          mctrl,
    input  logic          prod_ser,
    output logic [PW-1:0] result,
    output logic          res_valid,
    input  logic          res_ready
);

    localparam int CW = $clog2(PW + MUL_LAT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(PW + MUL_LAT - 1);
    localparam logic [CW-1:0] CNT_CAP  = CW'(MUL_LAT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state_r;
    state_t        state_s;
    logic [CW-1:0] cnt_r;
    logic [XW-1:0] areg_r;
    logic [YW-1:0] breg_r;
    logic [PW-1:0] result_r;
    logic          res_valid_r;

    // Next-state decode.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_valid) begin
                    state_s = SHIFT;
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                if (cnt_r == CNT_LAST) begin
                    state_s = DONE;
                end else begin
                    state_s = SHIFT;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State, operand latches, bit counter and product deserializer.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r     <= IDLE;
            cnt_r       <= {CW{1'b0}};
            areg_r      <= {XW{1'b0}};
            breg_r      <= {YW{1'b0}};
            result_r    <= {PW{1'b0}};
            res_valid_r <= 1'b0;
        end else begin
            state_r <= state_s;
            case (state_r)
                IDLE: begin
                    if (start_valid) begin
                        areg_r <= a_in;
                        breg_r <= b_in;
                        cnt_r  <= {CW{1'b0}};
                    end
                end
                SHIFT: begin
                    cnt_r  <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
                    // A is shifted out LSB-first; zeros fill in to pad the tail.
                    areg_r <= areg_r >> 1;
                    if (cnt_r >= CNT_CAP) begin
                        result_r <= {prod_ser, result_r[PW-1:1]};
                    end
                    if (cnt_r == CNT_LAST) begin
                        res_valid_r <= 1'b1;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid_r <= 1'b0;
                    end
                end
                default: begin
                    res_valid_r <= 1'b0;
                end
            endcase
        end
    end

    // Multiplier controls; reset forces a clear on the same edge.
    always_comb begin
        x_ser = 1'b0;
        mctrl = 1'b0;
        if (!rst) begin
            x_ser = 1'b0;
            mctrl = 1'b0;
        end else if (state_r == SHIFT) begin
            x_ser = areg_r[0];
            mctrl = 1'b1;
        end else begin
            x_ser = 1'b0;
            mctrl = 1'b0;
        end
    end

    assign start_ready = (state_r == IDLE);
    assign y_par       = breg_r;
    assign result      = result_r;
    assign res_valid   = res_valid_r;

endmodule
